exception_vector_unit: RTL and testbench
========================================

Name: exception_vector_unit

Overview:
- Upstream of the memory-address select stage; the only producer of the 32-bit exception vector address (`exc_addr`) that the control unit routes to memory with address-select code 2'b01.
- On a detected exception it latches the cause and the EPC, then drives the vector address.
- It sequences the memory read of the handler byte and returns the zero-extended byte as the new PC target.

Parameters:
- VEC_OPCODE, 32'd253, vector address for invalid opcode
- VEC_OVERFLOW, 32'd254, vector address for arithmetic overflow
- VEC_DIV0, 32'd255, vector address for division by zero
- MEM_LATENCY, 1, cycles from `mem_req` assertion to valid `mem_data_in`; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- exc_opcode  in  1  invalid-opcode flag, sampled in IDLE
- exc_overflow  in  1  overflow flag, sampled in IDLE
- exc_div0  in  1  divide-by-zero flag, sampled in IDLE
- pc_in  in  32  current PC, already incremented by 4
- mem_data_in  in  32  memory read data
- exc_addr  out  32  vector address, fed to the memory-address select input 2'b01
- epc_out  out  32  saved exception PC
- exc_cause  out  2  00 none, 01 opcode, 10 overflow, 11 div0
- exc_busy  out  1  high while the unit owns the memory port
- mem_req  out  1  control must select address code 2'b01 and issue a read
- pc_target  out  32  handler PC, {24'b0, byte}
- pc_target_valid  out  1  one-cycle pulse: `pc_target` valid, control loads PC

Behaviour:
- Reset (synchronous, active-high, has priority over all other activity):
  - state IDLE.
  - `exc_addr`, `epc_out` and `pc_target` are 0.
  - `exc_cause` is 00.
  - `exc_busy`, `mem_req` and `pc_target_valid` are 0.
  - The latency counter is 0.
- Reset asserted mid-sequence aborts the sequence; `pc_target_valid` is not emitted.
- State IDLE:
  - Any flag high at a rising edge latches the cause and moves to REQ.
  - Priority when several flags are high: opcode > overflow > div0.
  - `epc_out` <= `pc_in` - 32'd4, modulo 2^32; `pc_in` = 0 gives 32'hFFFFFFFC.
  - `exc_addr` <= the matching VEC_* value; `exc_cause` <= the matching code.
- State REQ:
  - `mem_req` = 1 and `exc_busy` = 1.
  - The latency counter loads MEM_LATENCY-1; go to WAIT.
- State WAIT:
  - `exc_busy` = 1 and `mem_req` = 1 (address held stable).
  - The counter decrements each cycle; when it is 0, go to LOAD.
- State LOAD:
  - `pc_target` <= {24'b0, `mem_data_in`[7:0]}; the upper data bits are ignored.
  - `mem_req` = 0 and `exc_busy` = 1; go to DONE.
- State DONE:
  - `pc_target_valid` = 1 for exactly one cycle and `exc_busy` = 0; go to IDLE.
- Cycle count: with MEM_LATENCY = 1, the `pc_target_valid` pulse occurs 4 cycles after the flag-sampling edge (REQ, WAIT, LOAD, DONE).
- Flags asserted while not in IDLE are ignored; they are neither queued nor counted.
- A flag still high when the unit returns to IDLE starts a new sequence; the control unit must clear its flags by DONE.
- `exc_addr`, `epc_out` and `exc_cause` hold their values after DONE until the next exception or reset.
- All outputs are registered except `mem_req`, `exc_busy` and `pc_target_valid`, which are decoded from the state register only (no input-to-output combinational path).

Test Plan:
- Reset hold: assert `reset` for 2 cycles with all flags high -> every output is 0, state IDLE, no `mem_req`.
- Opcode exception: `pc_in` = 32'h0000_0040, pulse `exc_opcode`, `mem_data_in` = 32'hAAAA_AA7C, MEM_LATENCY = 1:
  - `exc_addr` = 253, `epc_out` = 32'h3C, `exc_cause` = 01.
  - `mem_req` is high for 2 cycles; `pc_target` = 32'h7C with `pc_target_valid` one cycle at edge +4.
- Priority: `exc_overflow` and `exc_div0` high together, `pc_in` = 8 -> `exc_cause` = 10, `exc_addr` = 254, `epc_out` = 4.
- Latency and wrap: MEM_LATENCY = 3, `exc_div0`, `pc_in` = 0:
  - `epc_out` = 32'hFFFF_FFFC, `exc_addr` = 255.
  - `mem_req` is high for 4 cycles; `pc_target_valid` at edge +6.
- Busy masking: raise `exc_opcode` during WAIT of a div0 sequence -> `exc_cause` stays 11; exactly one `pc_target_valid` pulse.
- Mid-op reset: assert `reset` in WAIT -> next cycle all outputs are 0 and no `pc_target_valid`; a later `exc_overflow` completes normally.

Source files
------------

// File: rtl/exception_vector_unit.sv
// Exception vector unit: latches exception cause and EPC, drives the vector address,
// sequences the handler-byte memory read and returns the byte as the new PC target.
module exception_vector_unit #(
  parameter logic [31:0] VEC_OPCODE   = 32'd253,
  parameter logic [31:0] VEC_OVERFLOW = 32'd254,
  parameter logic [31:0] VEC_DIV0     = 32'd255,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] exc_addr,
  output logic [31:0] epc_out,
  output logic [1:0]  exc_cause,
  output logic        exc_busy,
  output logic        mem_req,
  output logic [31:0] pc_target,
  output logic        pc_target_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t     state, state_next;
  logic [3:0] lat_cnt;
  logic       any_flag;

  assign any_flag = exc_opcode | exc_overflow | exc_div0;

  always_comb begin
    state_next      = state;
    mem_req         = 1'b0;
    exc_busy        = 1'b0;
    pc_target_valid = 1'b0;
    case (state)
      S_IDLE: if (any_flag) state_next = S_REQ;
      S_REQ: begin
        mem_req    = 1'b1;
        exc_busy   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        mem_req  = 1'b1;
        exc_busy = 1'b1;
        if (lat_cnt == '0) state_next = S_LOAD;
      end
      S_LOAD: begin
        exc_busy   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        pc_target_valid = 1'b1;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      exc_addr  <= '0;
      epc_out   <= '0;
      exc_cause <= '0;
      pc_target <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (any_flag) begin
            epc_out <= pc_in - 32'd4;
            // Fixed priority: opcode over overflow over div0.
            if (exc_opcode) begin
              exc_cause <= 2'b01;
              exc_addr  <= VEC_OPCODE;
            end else if (exc_overflow) begin
              exc_cause <= 2'b10;
              exc_addr  <= VEC_OVERFLOW;
            end else begin
              exc_cause <= 2'b11;
              exc_addr  <= VEC_DIV0;
            end
          end
        end
        S_REQ:  lat_cnt <= LAT_M1;
        S_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 4'd1;
        S_LOAD: pc_target <= {24'b0, mem_data_in[7:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_vector_unit.sv
// Bench for exception_vector_unit: two instances (latency 1 and 3) share stimulus and
// are checked every cycle against a cycle-count reference model plus a pc_target scoreboard.
module tb_exception_vector_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_data_in;

  logic [31:0] exc_addr [2];
  logic [31:0] epc_out [2];
  logic [1:0]  exc_cause [2];
  logic        exc_busy [2];
  logic        mem_req [2];
  logic [31:0] pc_target [2];
  logic        pc_target_valid [2];

  always #5 clk = ~clk;

  exception_vector_unit #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .exc_addr(exc_addr[0]), .epc_out(epc_out[0]), .exc_cause(exc_cause[0]),
    .exc_busy(exc_busy[0]), .mem_req(mem_req[0]),
    .pc_target(pc_target[0]), .pc_target_valid(pc_target_valid[0])
  );

  exception_vector_unit #(.MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .exc_addr(exc_addr[1]), .epc_out(epc_out[1]), .exc_cause(exc_cause[1]),
    .exc_busy(exc_busy[1]), .mem_req(mem_req[1]),
    .pc_target(pc_target[1]), .pc_target_valid(pc_target_valid[1])
  );

  // Reference model: k = cycles since the flag-sampling edge (-1 when idle).
  int          lat [2] = '{1, 3};
  int          k [2] = '{-1, -1};
  logic [31:0] m_addr [2] = '{32'd0, 32'd0};
  logic [31:0] m_epc [2] = '{32'd0, 32'd0};
  logic [31:0] m_pct [2] = '{32'd0, 32'd0};
  logic [1:0]  m_cause [2] = '{2'd0, 2'd0};
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[lat=%0d] t=%0t: got %h expected %h", name, lat[inst], $time, act, exp);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i] = -1;
        m_addr[i] = 0; m_epc[i] = 0; m_pct[i] = 0; m_cause[i] = 0;
        if (i == 0) sb0.delete(); else sb1.delete();
      end else if (k[i] < 0) begin
        if (exc_opcode || exc_overflow || exc_div0) begin
          k[i] = 0;
          m_epc[i] = pc_in - 32'd4;
          if (exc_opcode) begin m_cause[i] = 2'b01; m_addr[i] = 32'd253; end
          else if (exc_overflow) begin m_cause[i] = 2'b10; m_addr[i] = 32'd254; end
          else begin m_cause[i] = 2'b11; m_addr[i] = 32'd255; end
        end
      end else begin
        k[i]++;
        if (k[i] == lat[i] + 2) begin
          m_pct[i] = {24'b0, mem_data_in[7:0]};
          if (i == 0) sb0.push_back(m_pct[i]); else sb1.push_back(m_pct[i]);
        end else if (k[i] == lat[i] + 3) begin
          k[i] = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] exp_pct;
      chk("mem_req", i, 32'(mem_req[i]), 32'((k[i] >= 0) && (k[i] <= lat[i])));
      chk("exc_busy", i, 32'(exc_busy[i]), 32'((k[i] >= 0) && (k[i] <= lat[i] + 1)));
      chk("pc_target_valid", i, 32'(pc_target_valid[i]), 32'(k[i] == lat[i] + 2));
      chk("exc_addr", i, exc_addr[i], m_addr[i]);
      chk("epc_out", i, epc_out[i], m_epc[i]);
      chk("exc_cause", i, 32'(exc_cause[i]), 32'(m_cause[i]));
      chk("pc_target_held", i, pc_target[i], m_pct[i]);
      if (pc_target_valid[i] === 1'b1) begin
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          n_total++;
          $display("FAIL sb_unexpected_pulse[lat=%0d] t=%0t: got pulse expected none", lat[i], $time);
        end else begin
          exp_pct = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("pc_target_pulse", i, pc_target[i], exp_pct);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flags(input logic op, input logic ov, input logic dz);
    exc_opcode = op; exc_overflow = ov; exc_div0 = dz;
  endtask

  initial begin
    reset = 1'b1;
    flags(1, 1, 1);
    pc_in = 32'h0;
    mem_data_in = 32'h0;
    cyc(2);
    reset = 1'b0;
    flags(0, 0, 0);
    cyc(1);

    // Opcode exception
    pc_in = 32'h0000_0040; mem_data_in = 32'hAAAA_AA7C;
    flags(1, 0, 0); cyc(1);
    flags(0, 0, 0); cyc(8);

    // Overflow and div0 together: overflow wins
    pc_in = 32'd8; mem_data_in = 32'h1234_5681;
    flags(0, 1, 1); cyc(1);
    flags(0, 0, 0); cyc(8);

    // Div0 with pc_in wrap, opcode raised while busy
    pc_in = 32'd0; mem_data_in = 32'hFFFF_FF00;
    flags(0, 0, 1); cyc(1);
    flags(0, 0, 0); cyc(2);
    flags(1, 0, 0); cyc(1);
    flags(0, 0, 0); cyc(8);

    // Mid-sequence reset, then a clean overflow
    pc_in = 32'h100; mem_data_in = 32'h0000_00EE;
    flags(0, 1, 0); cyc(1);
    flags(0, 0, 0); cyc(1);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(3);
    pc_in = 32'h204; mem_data_in = 32'h0000_0155;
    flags(0, 1, 0); cyc(1);
    flags(0, 0, 0); cyc(8);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      flags($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 149) == 0);
      pc_in = $urandom;
      mem_data_in = $urandom;
      cyc(1);
    end

    reset = 1'b0;
    flags(0, 0, 0);
    cyc(12);
    chk("sb_drained", 0, 32'(sb0.size()), 32'd0);
    chk("sb_drained", 1, 32'(sb1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
